// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the round-robin memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 2;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RD_WAIT,
      RD_RESP
   } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side handshake and memory-side bus shared by the arbiter and its environment.
interface mem_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 2,
   parameter int DATA_W  = 8
) ();

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        req_we;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        rvalid;
   logic [DATA_W-1:0]         rsp_rdata;
   logic [ADDR_W-1:0]         mem_addr;
   logic                      mem_wr_en;
   logic                      mem_rd_en;
   logic [DATA_W-1:0]         mem_wdata;
   logic [DATA_W-1:0]         mem_rdata;

   // The arbiter side.
   modport master (
      input  req, req_we, req_addr, req_wdata, mem_rdata,
      output gnt, rvalid, rsp_rdata, mem_addr, mem_wr_en, mem_rd_en, mem_wdata
   );

   // Requesters plus memory.
   modport slave (
      output req, req_we, req_addr, req_wdata, mem_rdata,
      input  gnt, rvalid, rsp_rdata, mem_addr, mem_wr_en, mem_rd_en, mem_wdata
   );

endinterface

// File: rtl/mem_rr_picker.sv
// Combinational round-robin search: first requester above last_i, wrapping.
module mem_rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_i,
   output logic [IDX_W-1:0]   winner_o,
   output logic               any_o
);

   logic [IDX_W-1:0] idx;

   // Scan from the farthest offset down so the nearest requester is the last to win.
   always_comb begin
      any_o    = 1'b0;
      winner_o = '0;
      idx      = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = IDX_W'((int'(last_i) + k) % NUM_REQ);
         if (req_i[idx]) begin
            any_o    = 1'b1;
            winner_o = idx;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sequencing one read or write per grant onto a single-port memory.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input logic         clk,
   input logic         reset,
   mem_arbiter_if.master bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    win_q, win_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic [IDX_W-1:0]    pick;
   logic                any_req;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
   logic [DATA_W-1:0]   rsp_q, rsp_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                wr_q, wr_d;
   logic                rd_q, rd_d;

   mem_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_i    (bus.req),
      .last_i   (last_q),
      .winner_o (pick),
      .any_o    (any_req)
   );

   // Output registers are loaded for the state being entered, so every output is a flop.
   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      last_d   = last_q;
      gnt_d    = '0;
      rvalid_d = '0;
      rsp_d    = rsp_q;
      addr_d   = '0;
      wdata_d  = '0;
      wr_d     = 1'b0;
      rd_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               win_d   = pick;
               last_d  = pick;
               gnt_d   = NUM_REQ'(1) << pick;
               addr_d  = bus.req_addr[int'(pick)*ADDR_W +: ADDR_W];
               wdata_d = bus.req_wdata[int'(pick)*DATA_W +: DATA_W];
               wr_d    = bus.req_we[pick];
               rd_d    = !bus.req_we[pick];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = wr_q ? IDLE : RD_WAIT;
         end
         RD_WAIT: begin
            rsp_d    = bus.mem_rdata;
            rvalid_d = NUM_REQ'(1) << win_q;
            state_d  = RD_RESP;
         end
         RD_RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         win_q    <= '0;
         last_q   <= IDX_W'(NUM_REQ - 1);
         gnt_q    <= '0;
         rvalid_q <= '0;
         rsp_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         last_q   <= last_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
         rsp_q    <= rsp_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.rvalid    = rvalid_q;
   assign bus.rsp_rdata = rsp_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_wr_en = wr_q;
   assign bus.mem_rd_en = rd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with four requesters and a 4x8 memory model.
module tb_mem_arbiter;

   localparam int NR = 4;
   localparam int AW = 2;
   localparam int DW = 8;

   typedef struct {
      logic [NR-1:0] v;
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            c;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t gq[$];
   exp_t rq[$];
   logic [DW-1:0] mem [4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   mem_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Memory model: synchronous write, read data registered one cycle after rd_en.
   always @(posedge clk) begin
      if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req[i]                 = 1'b1;
      bus.req_we[i]              = we;
      bus.req_addr[i*AW +: AW]   = a;
      bus.req_wdata[i*DW +: DW]  = d;
   endtask

   task automatic clr_req();
      bus.req       = '0;
      bus.req_we    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
   endtask

   task automatic exp_gnt(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int c);
      exp_t e;
      e.v = NR'(1) << i; e.we = we; e.a = a; e.d = d; e.c = c;
      gq.push_back(e);
   endtask

   task automatic exp_rv(input int i, input logic [DW-1:0] d, input int c);
      exp_t e;
      e.v = NR'(1) << i; e.we = 1'b0; e.a = '0; e.d = d; e.c = c;
      rq.push_back(e);
   endtask

   // Monitor: pops an expectation whenever the DUT presents a grant or read response.
   always @(negedge clk) begin
      exp_t e;
      chk("gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
      chk("rvalid_onehot", 32'($onehot0(bus.rvalid)), 32'd1);
      chk("strobe_excl", 32'(bus.mem_wr_en & bus.mem_rd_en), 32'd0);
      if (bus.gnt != '0) begin
         if (gq.size() == 0) begin
            chk("unexpected_gnt", 32'(bus.gnt), 32'd0);
         end else begin
            e = gq.pop_front();
            chk("gnt", 32'(bus.gnt), 32'(e.v));
            chk("gnt_cycle", 32'(cyc), 32'(e.c));
            chk("mem_wr_en", 32'(bus.mem_wr_en), 32'(e.we));
            chk("mem_rd_en", 32'(bus.mem_rd_en), 32'(!e.we));
            chk("mem_addr", 32'(bus.mem_addr), 32'(e.a));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(e.d));
         end
      end else begin
         chk("idle_bus", {bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata}, 32'd0);
      end
      if (bus.rvalid != '0) begin
         if (rq.size() == 0) begin
            chk("unexpected_rvalid", 32'(bus.rvalid), 32'd0);
         end else begin
            e = rq.pop_front();
            chk("rvalid", 32'(bus.rvalid), 32'(e.v));
            chk("rvalid_cycle", 32'(cyc), 32'(e.c));
            chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.d));
         end
      end
   end

   initial begin
      reset = 1'b1;
      clr_req();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_gnt_rvalid", {bus.gnt, bus.rvalid}, 32'd0);
      chk("reset_mem", {bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata}, 32'd0);
      chk("reset_rsp", 32'(bus.rsp_rdata), 32'd0);
      reset = 1'b0;
      tick();

      // Single-cycle write pulse from requester 0.
      set_req(0, 1'b1, 2'd2, 8'hA5);
      exp_gnt(0, 1'b1, 2'd2, 8'hA5, cyc + 1);
      tick();
      clr_req();
      repeat (3) tick();

      // Read back by requester 1.
      set_req(1, 1'b0, 2'd2, 8'h00);
      exp_gnt(1, 1'b0, 2'd2, 8'h00, cyc + 1);
      exp_rv(1, 8'hA5, cyc + 3);
      tick();
      clr_req();
      repeat (5) tick();

      // Two held write requests alternate every other cycle.
      set_req(0, 1'b1, 2'd0, 8'h11);
      set_req(1, 1'b1, 2'd1, 8'h22);
      exp_gnt(0, 1'b1, 2'd0, 8'h11, cyc + 1);
      exp_gnt(1, 1'b1, 2'd1, 8'h22, cyc + 3);
      exp_gnt(0, 1'b1, 2'd0, 8'h11, cyc + 5);
      exp_gnt(1, 1'b1, 2'd1, 8'h22, cyc + 7);
      repeat (7) tick();
      clr_req();
      repeat (3) tick();

      // Fresh reset puts last_grant at 3; requesters 1 and 3 wrap around.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      set_req(3, 1'b1, 2'd0, 8'h3C);
      set_req(1, 1'b1, 2'd3, 8'h31);
      exp_gnt(1, 1'b1, 2'd3, 8'h31, cyc + 1);
      exp_gnt(3, 1'b1, 2'd0, 8'h3C, cyc + 3);
      exp_gnt(1, 1'b1, 2'd3, 8'h31, cyc + 5);
      exp_gnt(3, 1'b1, 2'd0, 8'h3C, cyc + 7);
      repeat (7) tick();
      clr_req();
      repeat (3) tick();

      // Requester 2 reads what requester 1 wrote.
      set_req(2, 1'b0, 2'd3, 8'h00);
      exp_gnt(2, 1'b0, 2'd3, 8'h00, cyc + 1);
      exp_rv(2, 8'h31, cyc + 3);
      tick();
      clr_req();
      repeat (5) tick();

      // Read by requester 0 aborted by reset during RD_WAIT: no rvalid may follow.
      set_req(0, 1'b0, 2'd2, 8'h00);
      exp_gnt(0, 1'b0, 2'd2, 8'h00, cyc + 1);
      tick();
      clr_req();
      tick();
      #2;
      reset = 1'b1;
      #1;
      chk("abort_gnt_rvalid", {bus.gnt, bus.rvalid}, 32'd0);
      chk("abort_mem", {bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata}, 32'd0);
      chk("abort_rsp", 32'(bus.rsp_rdata), 32'd0);
      repeat (2) tick();
      reset = 1'b0;
      repeat (4) tick();

      // Requester 1 alone after the abort.
      set_req(1, 1'b0, 2'd0, 8'h00);
      exp_gnt(1, 1'b0, 2'd0, 8'h00, cyc + 1);
      exp_rv(1, 8'h3C, cyc + 3);
      tick();
      clr_req();
      repeat (6) tick();

      chk("gnt_queue_empty", 32'(gq.size()), 32'd0);
      chk("rvalid_queue_empty", 32'(rq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
